ws2812_serializer: RTL

//  Downstream of the Game of Life controller: converts one 24-bit pixel per request into the

---
 rtl/ws2812_serializer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/ws2812_serializer.sv
// WS2812B single-wire NRZ serializer: one 24-bit GRB pixel per transmit strobe, plus the latch gap.
// Optional build macro WS2812_DIM_EN: each channel is right-shifted by DIM_SHIFT at capture.
`timescale 1ns/1ps
module ws2812_serializer #(
  parameter int BIT_CYCLES   = 15,
  parameter int T0H_CYCLES   = 4,
  parameter int T1H_CYCLES   = 8,
  parameter int RESET_CYCLES = 600,
  parameter int DIM_SHIFT    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] red_data,
  input  logic [7:0] green_data,
  input  logic [7:0] blue_data,
  input  logic       load_sreg,
  input  logic       transmit_pixel,
  input  logic       latch,
  output logic       busy,
  output logic       pixel_done,
  output logic       latch_done,
  output logic       dout
);

  localparam int CNT_MAX = (BIT_CYCLES > RESET_CYCLES) ? BIT_CYCLES : RESET_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);

  generate
    if (!((T0H_CYCLES < T1H_CYCLES) && (T1H_CYCLES < BIT_CYCLES)) || (DIM_SHIFT > 7)) begin : g_param_check
      $fatal(1, "ws2812_serializer: need T0H_CYCLES < T1H_CYCLES < BIT_CYCLES and DIM_SHIFT <= 7");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SEND, LATCH} state_t;

  state_t             state, state_next;
  logic [23:0]        sreg, sreg_next;
  logic [4:0]         bit_cnt, bit_next;
  logic [CNT_W-1:0]   cyc_cnt, cyc_next;
  logic               dout_next;
  logic [7:0]         green_cap, red_cap, blue_cap;
  logic               last_cyc, pixel_end, latch_end, accept;
  logic [CNT_W-1:0]   high_cycles;

`ifdef WS2812_DIM_EN
  assign green_cap = green_data >> DIM_SHIFT;
  assign red_cap   = red_data   >> DIM_SHIFT;
  assign blue_cap  = blue_data  >> DIM_SHIFT;
`else
  assign green_cap = green_data;
  assign red_cap   = red_data;
  assign blue_cap  = blue_data;
`endif

  // The final cycle of a pixel or of the latch gap behaves like IDLE so frames can run back-to-back.
  assign last_cyc  = (cyc_cnt == CNT_W'(BIT_CYCLES - 1));
  assign pixel_end = (state == SEND) && last_cyc && (bit_cnt == 5'd23);
  assign latch_end = (state == LATCH) && (cyc_cnt == CNT_W'(RESET_CYCLES - 1));
  assign accept    = (state == IDLE) || pixel_end || latch_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sreg    <= '0;
      bit_cnt <= '0;
      cyc_cnt <= '0;
      dout    <= 1'b0;
    end else begin
      state   <= state_next;
      sreg    <= sreg_next;
      bit_cnt <= bit_next;
      cyc_cnt <= cyc_next;
      dout    <= dout_next;
    end
  end

  always_comb begin
    state_next = state;
    sreg_next  = sreg;
    bit_next   = bit_cnt;
    cyc_next   = cyc_cnt;
    case (state)
      SEND: begin
        if (last_cyc) begin
          cyc_next  = '0;
          sreg_next = {sreg[22:0], 1'b0};
          bit_next  = pixel_end ? 5'd0 : bit_cnt + 5'd1;
        end else begin
          cyc_next = cyc_cnt + 1'b1;
        end
        if (pixel_end) begin
          state_next = IDLE;
        end
      end
      LATCH: begin
        if (latch_end) begin
          cyc_next   = '0;
          state_next = IDLE;
        end else begin
          cyc_next = cyc_cnt + 1'b1;
        end
      end
      default: ;
    endcase
    // Capture precedes transmit so a combined strobe sends the freshly loaded pixel.
    if (accept) begin
      if (load_sreg) begin
        sreg_next = {green_cap, red_cap, blue_cap};
      end
      if (transmit_pixel) begin
        state_next = SEND;
        bit_next   = '0;
        cyc_next   = '0;
      end else if (latch) begin
        state_next = LATCH;
        cyc_next   = '0;
      end
    end
  end

  always_comb begin
    high_cycles = sreg[23] ? CNT_W'(T1H_CYCLES) : CNT_W'(T0H_CYCLES);
    dout_next   = (state == SEND) && (cyc_cnt < high_cycles);
    busy        = (state != IDLE);
    pixel_done  = pixel_end;
    latch_done  = latch_end;
  end

endmodule
